wb_arbiter: RTL and testbench

- Writeback arbiter for the execution cluster. Sits directly upstream of rd_mux and generates its rd_sel.
- Collects completion requests from the ADD, MULT and MULADD controllers and grants one register-file write per cycle, round-robin.
- Drives the register-file write enable and write data, aligned with the rd that rd_mux produces.
- Keeps a per-register busy scoreboard so the issue stage can stall on a pending destination.

---
 rtl/wb_arbiter_pkg.sv | 49 ++++
 rtl/wb_arbiter_if.sv | 52 +++++
 rtl/wb_scoreboard.sv | 60 ++++++
 rtl/wb_arbiter.sv | 93 +++++++++
 tb/tb_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter_pkg
// Purpose : Shared rd_sel codes, bus widths and the round-robin pick helper
//           used by the writeback arbiter and its scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
package wb_arbiter_pkg;

  // rd_sel codes, shared with rd_mux
  localparam logic [1:0] ADD    = 2'b00;
  localparam logic [1:0] MULT   = 2'b01;
  localparam logic [1:0] MULADD = 2'b10;

  localparam int ADDR_WIDTH          = 4;
  localparam int NUMBER_OF_REGISTERS = 12;
  localparam int DATA_WIDTH          = 16;
  localparam int NUM_SOURCES         = 3;

  typedef struct packed {
    logic       valid;
    logic [1:0] sel;
  } grant_t;

  // Source code that follows s in round-robin order; MULADD wraps to ADD.
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == MULADD) ? ADD : s + 2'd1;
  endfunction

  // First requesting source found when walking the ring from ptr.
  function automatic grant_t rr_pick(input logic [NUM_SOURCES-1:0] req,
                                     input logic [1:0] ptr);
    grant_t     g;
    logic [1:0] s;
    g.valid = 1'b0;
    g.sel   = ptr;
    s       = ptr;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!g.valid && req[s]) begin
        g.valid = 1'b1;
        g.sel   = s;
      end
      s = next_src(s);
    end
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter_if
// Purpose : Completion-request, register-file write and issue/scoreboard
//           signals between the execution controllers and the arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                           add_done;
  logic                           mult_done;
  logic                           muladd_done;
  logic [ADDR_WIDTH-1:0]          rd_add_cont;
  logic [ADDR_WIDTH-1:0]          rd_mult_cont;
  logic [ADDR_WIDTH-1:0]          rd_muladd_cont;
  logic [DATA_WIDTH-1:0]          add_result;
  logic [DATA_WIDTH-1:0]          mult_result;
  logic [DATA_WIDTH-1:0]          muladd_result;
  logic                           add_ack;
  logic                           mult_ack;
  logic                           muladd_ack;
  logic [1:0]                     rd_sel;
  logic                           wr_en;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic                           issue_valid;
  logic [ADDR_WIDTH-1:0]          issue_rd;
  logic                           issue_stall;
  logic [NUMBER_OF_REGISTERS-1:0] reg_busy;

  // Controllers / issue stage side
  modport master (
    output add_done, mult_done, muladd_done,
    output rd_add_cont, rd_mult_cont, rd_muladd_cont,
    output add_result, mult_result, muladd_result,
    output issue_valid, issue_rd,
    input  add_ack, mult_ack, muladd_ack,
    input  rd_sel, wr_en, wr_data, issue_stall, reg_busy
  );

  // Arbiter side
  modport slave (
    input  add_done, mult_done, muladd_done,
    input  rd_add_cont, rd_mult_cont, rd_muladd_cont,
    input  add_result, mult_result, muladd_result,
    input  issue_valid, issue_rd,
    output add_ack, mult_ack, muladd_ack,
    output rd_sel, wr_en, wr_data, issue_stall, reg_busy
  );

endinterface
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : wb_scoreboard
// Purpose : Per-register busy bitmap. Issue sets, writeback clears, set wins
//           on a collision; issue_stall flags dispatch to a busy register.
// Rev     : 1.0  initial release
// ============================================================================
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  output logic                           issue_stall,
  output logic [NUMBER_OF_REGISTERS-1:0] reg_busy
);

  localparam logic [NUMBER_OF_REGISTERS-1:0] C_BIT0 = NUMBER_OF_REGISTERS'(1);

  logic [NUMBER_OF_REGISTERS-1:0] r_busy;
  logic [NUMBER_OF_REGISTERS-1:0] w_set_mask;
  logic [NUMBER_OF_REGISTERS-1:0] w_clr_mask;
  logic                           w_issue_in_range;
  logic                           w_wr_in_range;
  logic                           w_stall;

  // Addresses beyond the register file are invisible to the scoreboard.
  assign w_issue_in_range = (32'(issue_rd) < 32'(NUMBER_OF_REGISTERS));
  assign w_wr_in_range    = (32'(wr_addr)  < 32'(NUMBER_OF_REGISTERS));

  assign w_stall     = issue_valid & w_issue_in_range & r_busy[issue_rd];
  assign issue_stall = w_stall;
  assign reg_busy    = r_busy;

  // One-hot set/clear masks for this edge; a stalled issue sets nothing.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (issue_valid && !w_stall && w_issue_in_range) begin
      w_set_mask = C_BIT0 << issue_rd;
    end
    if (wr_en && w_wr_in_range) begin
      w_clr_mask = C_BIT0 << wr_addr;
    end
  end

  // Clear first, then set, so a same-cycle issue keeps its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Purpose : Round-robin writeback arbiter for ADD/MULT/MULADD completions.
//           Drives rd_sel to rd_mux together with the register-file write
//           and one-cycle acks; hosts the busy scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);

  logic [NUM_SOURCES-1:0] w_done;
  logic [NUM_SOURCES-1:0] w_req;
  logic [NUM_SOURCES-1:0] r_ack;
  grant_t                 w_grant;
  logic [1:0]             r_ptr;
  logic [1:0]             r_rd_sel;
  logic                   r_wr_en;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [DATA_WIDTH-1:0]  w_grant_result;
  logic [ADDR_WIDTH-1:0]  w_grant_rd;

  // A source acked this cycle still holds done; mask it so it is not
  // granted a second time for the same result.
  assign w_done  = {bus.muladd_done, bus.mult_done, bus.add_done};
  assign w_req   = w_done & ~r_ack;
  assign w_grant = rr_pick(w_req, r_ptr);

  // Select the granted source's result and destination.
  always_comb begin
    w_grant_result = bus.add_result;
    w_grant_rd     = bus.rd_add_cont;
    case (w_grant.sel)
      MULT: begin
        w_grant_result = bus.mult_result;
        w_grant_rd     = bus.rd_mult_cont;
      end
      MULADD: begin
        w_grant_result = bus.muladd_result;
        w_grant_rd     = bus.rd_muladd_cont;
      end
      default: ;
    endcase
  end

  // Grant register: write strobe, ack pulse, select and ring pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_ack     <= '0;
      r_rd_sel  <= ADD;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_ptr     <= ADD;
    end else if (w_grant.valid) begin
      r_wr_en   <= 1'b1;
      r_ack     <= 3'b001 << w_grant.sel;
      r_rd_sel  <= w_grant.sel;
      r_wr_data <= w_grant_result;
      r_wr_addr <= w_grant_rd;
      r_ptr     <= next_src(w_grant.sel);
    end else begin
      r_wr_en   <= 1'b0;
      r_ack     <= '0;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (r_wr_en),
    .wr_addr     (r_wr_addr),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .issue_stall (bus.issue_stall),
    .reg_busy    (bus.reg_busy)
  );

  assign bus.add_ack    = r_ack[0];
  assign bus.mult_ack   = r_ack[1];
  assign bus.muladd_ack = r_ack[2];
  assign bus.rd_sel     = r_rd_sel;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_data    = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter
// Purpose : Self-checking bench for wb_arbiter: directed scenarios followed
//           by randomized traffic against a cycle-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NREG = NUMBER_OF_REGISTERS;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // rd_mux as it sits downstream: picks the controller rd by rd_sel
  logic [ADDR_WIDTH-1:0] mux_rd;
  always_comb begin
    mux_rd = 'x;
    case (bus.rd_sel)
      2'b00:   mux_rd = bus.rd_add_cont;
      2'b01:   mux_rd = bus.rd_mult_cont;
      2'b10:   mux_rd = bus.rd_muladd_cont;
      default: mux_rd = 'x;
    endcase
  end

  // ---------------- reference model state ----------------
  int              ptr;
  bit              m_wr_en;
  bit [2:0]        m_ack;
  int              m_rd_sel;
  logic [15:0]     m_wr_data;
  int              m_wr_addr;
  bit [NREG-1:0]   m_busy;
  // controllers
  bit              pend [3];
  bit              drop [3];
  bit              stream [3];
  logic [3:0]      c_rd [3];
  logic [15:0]     c_res [3];
  logic [3:0]      nrd [3];
  logic [15:0]     nres [3];
  bit              cur_iv;
  int              cur_ird;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_stall();
    return cur_iv && (cur_ird < NREG) && m_busy[cur_ird];
  endfunction

  task automatic drive_bus();
    bus.add_done       = pend[0];
    bus.mult_done      = pend[1];
    bus.muladd_done    = pend[2];
    bus.rd_add_cont    = c_rd[0];
    bus.rd_mult_cont   = c_rd[1];
    bus.rd_muladd_cont = c_rd[2];
    bus.add_result     = c_res[0];
    bus.mult_result    = c_res[1];
    bus.muladd_result  = c_res[2];
    bus.issue_valid    = cur_iv;
    bus.issue_rd       = 4'(cur_ird);
  endtask

  task automatic check_outputs();
    check("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
    check("acks", 32'({bus.muladd_ack, bus.mult_ack, bus.add_ack}), 32'(m_ack));
    check("rd_sel", 32'(bus.rd_sel), 32'(m_rd_sel));
    check("rd_sel_legal", 32'(bus.rd_sel == 2'b11), 32'd0);
    check("reg_busy", 32'(bus.reg_busy), 32'(m_busy));
    if (m_wr_en) begin
      check("wr_data", 32'(bus.wr_data), 32'(m_wr_data));
      check("rd_mux_rd", 32'(mux_rd), 32'(m_wr_addr));
    end
  endtask

  // Expected state after the coming rising edge, from the current inputs.
  task automatic predict();
    bit       stall;
    bit [2:0] req;
    int       g;
    stall = exp_stall();
    for (int s = 0; s < 3; s++) req[s] = pend[s] && !m_ack[s];
    if (m_wr_en && m_wr_addr < NREG) m_busy[m_wr_addr] = 1'b0;
    if (cur_iv && !stall && cur_ird < NREG) m_busy[cur_ird] = 1'b1;
    g = -1;
    for (int i = 0; i < 3; i++) begin
      if (g < 0 && req[(ptr + i) % 3]) g = (ptr + i) % 3;
    end
    if (g >= 0) begin
      m_wr_en   = 1'b1;
      m_rd_sel  = g;
      m_wr_data = c_res[g];
      m_wr_addr = int'(c_rd[g]);
      m_ack     = 3'(1 << g);
      ptr       = (g + 1) % 3;
    end else begin
      m_wr_en = 1'b0;
      m_ack   = 3'b000;
    end
  endtask

  // One cycle: check last edge, advance controllers, drive, predict next edge.
  task automatic step(input bit [2:0] raise, input bit iv, input int ird);
    @(negedge clk);
    check_outputs();
    for (int s = 0; s < 3; s++) begin
      if (drop[s]) begin
        drop[s] = 1'b0;
        if (stream[s]) begin
          c_rd[s]  = nrd[s];
          c_res[s] = nres[s];
        end else begin
          pend[s] = 1'b0;
        end
      end else if (m_ack[s]) begin
        drop[s] = 1'b1;
      end else if (!pend[s] && raise[s]) begin
        pend[s]  = 1'b1;
        c_rd[s]  = nrd[s];
        c_res[s] = nres[s];
      end
    end
    cur_iv  = iv;
    cur_ird = ird;
    drive_bus();
    #1;
    check("issue_stall", 32'(bus.issue_stall), 32'(exp_stall()));
    predict();
  endtask

  // Asynchronous reset in the middle of a cycle; pending dones survive.
  task automatic do_reset(input bit pre_check);
    @(negedge clk);
    if (pre_check) check_outputs();
    cur_iv = 1'b0;
    drive_bus();
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_acks", 32'({bus.muladd_ack, bus.mult_ack, bus.add_ack}), 32'd0);
    check("rst_rd_sel", 32'(bus.rd_sel), 32'd0);
    check("rst_reg_busy", 32'(bus.reg_busy), 32'd0);
    ptr = 0; m_wr_en = 0; m_ack = 0; m_rd_sel = 0; m_wr_data = 0; m_wr_addr = 0; m_busy = 0;
    for (int s = 0; s < 3; s++) drop[s] = 1'b0;
    #1 rst_n = 1'b1;
    predict();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      pend[s] = 0; drop[s] = 0; stream[s] = 0; c_rd[s] = 0; c_res[s] = 0; nrd[s] = 0; nres[s] = 0;
    end
    cur_iv = 0; cur_ird = 0;
    drive_bus();
    do_reset(1'b0);

    // Single ADD
    nrd[0] = 4'd5; nres[0] = 16'hDEAD;
    step(3'b001, 1'b0, 0);
    step(3'b000, 1'b0, 0);
    check("add_wr_en", 32'(bus.wr_en), 32'd1);
    check("add_wr_data", 32'(bus.wr_data), 32'hDEAD);
    check("add_ack", 32'(bus.add_ack), 32'd1);
    check("add_rd_mux", 32'(mux_rd), 32'd5);
    step(3'b000, 1'b0, 0);
    check("add_wr_en_off", 32'(bus.wr_en), 32'd0);
    drain(2);

    // Reset while the ADD grant is live; ADD is re-granted after release
    nrd[0] = 4'd9; nres[0] = 16'h1234;
    step(3'b001, 1'b0, 0);
    do_reset(1'b1);
    step(3'b000, 1'b0, 0);
    check("post_rst_add_ack", 32'(bus.add_ack), 32'd1);
    drain(3);

    // All three requesting from reset
    do_reset(1'b1);
    nrd[0] = 4'd1; nres[0] = 16'h0A0A;
    nrd[1] = 4'd2; nres[1] = 16'h0B0B;
    nrd[2] = 4'd4; nres[2] = 16'h0C0C;
    step(3'b111, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      step(3'b000, 1'b0, 0);
      check("all3_rd_sel", 32'(bus.rd_sel), 32'(k));
    end
    drain(3);

    // ADD and MULT held continuously alternate
    do_reset(1'b1);
    stream[0] = 1; stream[1] = 1;
    nrd[0] = 4'd6; nres[0] = 16'h1111;
    nrd[1] = 4'd8; nres[1] = 16'h2222;
    step(3'b011, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      nres[0] = 16'(16'h1000 + k); nres[1] = 16'(16'h2000 + k);
      step(3'b000, 1'b0, 0);
      check("alt_rd_sel", 32'(bus.rd_sel), 32'(k % 2));
      check("alt_wr_en", 32'(bus.wr_en), 32'd1);
    end
    stream[0] = 0; stream[1] = 0;
    drain(4);

    // Scoreboard
    do_reset(1'b1);
    step(3'b000, 1'b1, 3);
    step(3'b000, 1'b1, 3);
    check("sb_busy3", 32'(bus.reg_busy), 32'h008);
    check("sb_stall3", 32'(bus.issue_stall), 32'd1);
    nrd[1] = 4'd3; nres[1] = 16'h3333;
    step(3'b010, 1'b0, 0);
    check("sb_stall_nochange", 32'(bus.reg_busy), 32'h008);
    step(3'b000, 1'b1, 3);
    check("sb_stall_during_wb", 32'(bus.issue_stall), 32'd1);
    step(3'b000, 1'b1, 3);
    check("sb_stall_released", 32'(bus.issue_stall), 32'd0);
    nrd[0] = 4'd7; nres[0] = 16'h7777;
    step(3'b001, 1'b0, 0);
    step(3'b000, 1'b1, 7);
    check("sb_setclr_stall", 32'(bus.issue_stall), 32'd0);
    step(3'b000, 1'b1, 13);
    check("sb_set_wins", 32'(bus.reg_busy[7]), 32'd1);
    check("sb_oor_stall", 32'(bus.issue_stall), 32'd0);
    step(3'b000, 1'b0, 0);
    check("sb_oor_ignored", 32'(bus.reg_busy), 32'h088);
    drain(3);

    // Randomized traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 50 == 0) begin
        for (int s = 0; s < 3; s++) stream[s] = ($urandom_range(0, 3) == 0);
      end
      for (int s = 0; s < 3; s++) begin
        nrd[s]  = 4'($urandom_range(0, 15));
        nres[s] = 16'($urandom);
      end
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end
    for (int s = 0; s < 3; s++) stream[s] = 0;
    drain(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
